// File: rtl/mu0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mu0_pkg
//  Description : Shared MU0 definitions: bus widths, opcode constants used
//                when building program images, and the boot-loader state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package mu0_pkg;

    localparam int MU0_ADDR_W = 12;
    localparam int MU0_DATA_W = 16;

    // MU0 opcodes occupy the top nibble of each instruction word
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_CHECK   = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RUN     = 3'd5,
        ST_FAIL    = 3'd6
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/mu0_loader_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : mu0_loader_checksum
//  Description : Clear/accumulate running sum, modulo 2^DATA_W (carries
//                discarded). Used for both the write and readback sums.
//  Revision    : 1.0  initial release
// ============================================================================
module mu0_loader_checksum #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] sum
);

    // Running sum; clear has priority over accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum + data_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mu0_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mu0_loader
//  Description : MU0 boot loader. Takes a valid/ready program stream, writes
//                it to memory over the MU0 bus while holding the core in
//                reset, optionally verifies it by readback checksum, then
//                hands the bus back and releases the core.
//  Options     : MU0_LOADER_VERIFY_EN - build the VERIFY/CHECK readback pass
//  Revision    : 1.0  initial release
// ============================================================================
module mu0_loader
    import mu0_pkg::*;
#(
    parameter int ADDR_W    = MU0_ADDR_W,
    parameter int DATA_W    = MU0_DATA_W,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_word,
    input  logic              in_last,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_address,
    output logic              memrq,
    output logic              rnw,
    output logic              bus_own,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic              wr_pend;   // a word is held and is written this cycle
    logic              last_q;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  count;
    logic              accept;

    assign accept   = in_valid && in_ready;
    assign out_data = word_q;
    assign error    = (state == ST_FAIL);

`ifdef MU0_LOADER_VERIFY_EN
    logic [CNT_W-1:0]  rd_idx;
    logic              rd_pend;   // read issued last cycle, data on mem_rdata now
    logic              rd_issue;
    logic [DATA_W-1:0] wr_sum;
    logic [DATA_W-1:0] rd_sum;

    assign rd_issue = (state == ST_VERIFY) && (rd_idx != count);

    // Readback address pointer and one-cycle read-data pipeline flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    mu0_loader_checksum #(.DATA_W(DATA_W)) u_wr_sum (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .acc_en  ((state == ST_WRITE) && wr_pend),
        .data_in (word_q),
        .sum     (wr_sum)
    );

    mu0_loader_checksum #(.DATA_W(DATA_W)) u_rd_sum (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .acc_en  (rd_pend),
        .data_in (mem_rdata),
        .sum     (rd_sum)
    );
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stream capture and word counter; an overflow word is never captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
            count   <= '0;
        end else if (state == ST_WRITE) begin
            if (wr_pend) begin
                wr_pend <= 1'b0;
                count   <= count + 1'b1;
            end else if (accept && (count != MAX_CNT)) begin
                wr_pend <= 1'b1;
                word_q  <= in_word;
                last_q  <= in_last;
            end
        end
    end

    // Next state and bus/handshake outputs
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        memrq       = 1'b0;
        rnw         = 1'b1;
        out_address = BASE;
        bus_own     = 1'b1;
        cpu_rst_n   = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_pend) begin
                    memrq       = 1'b1;
                    rnw         = 1'b0;
                    out_address = BASE + ADDR_W'(count);
                    if (last_q) begin
`ifdef MU0_LOADER_VERIFY_EN
                        state_nxt = ST_VERIFY;
`else
                        state_nxt = ST_RELEASE;
`endif
                    end
                end else begin
                    in_ready = 1'b1;
                    if (in_valid && (count == MAX_CNT)) begin
                        state_nxt = ST_FAIL;
                    end
                end
            end
`ifdef MU0_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (rd_issue) begin
                    memrq       = 1'b1;
                    out_address = BASE + ADDR_W'(rd_idx);
                end else begin
                    // last read data is being summed this cycle
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = (wr_sum == rd_sum) ? ST_RELEASE : ST_FAIL;
            end
`endif
            ST_RELEASE: begin
                bus_own   = 1'b0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                bus_own   = 1'b0;
                cpu_rst_n = 1'b1;
                done      = 1'b1;
            end
            ST_FAIL: begin
                bus_own = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mu0_loader.md
# mu0_loader

Bus-initiator boot loader for the MU0 system. Accepts a program image as a valid/ready word stream, writes it into `memory_32x16` over the MU0 memory bus (`memrq`/`rnw`/address/data), optionally verifies it by readback checksum, then releases the MU0 core from reset. It replaces bench-side forcing of memory contents and owns the bus only while the core is held in reset.

## Interface
- `ADDR_W`, 12: memory address width.
- `DATA_W`, 16: word width.
- `BASE_ADDR`, 0: address of the first loaded word.
- `MAX_WORDS`, 32: image capacity, matching memory depth.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader accepts a word this cycle.
- `in_word` in DATA_W: program word.
- `in_last` in 1: marks the final image word.
- `mem_rdata` in DATA_W: memory `out_data`.
- `out_data` out DATA_W: write data to memory `in_data`.
- `out_address` out ADDR_W: memory address.
- `memrq` out 1: memory request.
- `rnw` out 1: 1 = read, 0 = write.
- `bus_own` out 1: loader drives the bus. The top-level muxes the loader or MU0 onto memory with this signal.
- `cpu_rst_n` out 1: drives MU0 `rst_n`.
- `done` out 1: image loaded and core released (sticky).
- `error` out 1: overflow or verify mismatch (sticky).

## Operation
- States: `IDLE`, `WRITE`, `VERIFY`, `CHECK`, `RELEASE`, `RUN`, `FAIL`.
- Reset values:
  - `in_ready`=0, `memrq`=0, `rnw`=1.
  - `out_address`=`BASE_ADDR`, `out_data`=0.
  - `bus_own`=1, `cpu_rst_n`=0, `done`=0, `error`=0.
- `IDLE` to `WRITE`: one cycle after reset deassertion.
- `WRITE` handshake:
  - `in_ready`=1.
  - On `in_valid && in_ready`, the word is registered and presented next cycle with `memrq`=1, `rnw`=0 at `BASE_ADDR + count`. `count` then increments.
  - `in_ready` drops for that write cycle, giving a throughput of one word per 2 cycles.
- Accepted word with `in_last`=1: after its write, go to `VERIFY` (macro on) or `RELEASE` (macro off).
- Overflow: a word accepted while `count == MAX_WORDS` is not written. It sets `error` and goes to `FAIL`.
- `VERIFY`: issue reads `BASE_ADDR`..`BASE_ADDR+count-1` with `memrq`=1, `rnw`=1, and accumulate the returned words.
- `CHECK`: compare the readback sum with the write sum.
  - Equal: go to `RELEASE`.
  - Different: set `error` and go to `FAIL`.
- `RELEASE`: `memrq`=0, `bus_own`=0 for one cycle.
- `RUN`: `cpu_rst_n`=1 and `done`=1. Terminal until `rst`.
- `FAIL`: `cpu_rst_n` held 0, `bus_own`=0, `in_ready`=0. Terminal until `rst`.
- Checksum arithmetic: unsigned modulo 2^DATA_W; carries are discarded.
- `rst` mid-load: all outputs return to reset values at once; partial memory contents are not cleared.
- `in_valid` outside `WRITE`: ignored; no words are dropped silently, because `in_ready`=0.

## Timing
- Memory writes on the rising edge where `memrq`=1, `rnw`=0.
- Read data is valid on `mem_rdata` one cycle after the read request.
- Verify issues one read per cycle, pipelined. The final compare occurs 1 cycle after the last read data arrives.
- Load latency for N words: 2N cycles in `WRITE`, plus N+2 cycles of verify, plus 1 cycle of `RELEASE`.
- `cpu_rst_n` rises exactly one cycle after `bus_own` falls, so there is no bus contention.

## Configuration
- `MU0_LOADER_VERIFY_EN` defined:
  - `VERIFY`/`CHECK` states are present.
  - Write and readback checksum accumulators are present.
  - `error` can flag a mismatch.
- Undefined:
  - `WRITE` goes directly to `RELEASE`.
  - No accumulators are built.
  - `error` is raised by overflow only.

## Structure
- Shared package `mu0_pkg` holds:
  - the state enum;
  - `ADDR_W`/`DATA_W` defaults;
  - the MU0 opcode constants (LDA 0, STO 1, ADD 2, SUB 3, JNE 6, STP 7), for benches building images.
- Sub-module `mu0_loader_checksum`: a clear/accumulate/result 16-bit adder, instantiated twice (write sum, read sum) only under the macro.

## Test plan
- 21-word image (`0x0013`, `0x1012`, ..., `0x0001`, last on word 20), macro on:
  - memory[0..20] match the image;
  - `done`=1 and `cpu_rst_n`=1 after 42+23+1 cycles;
  - MU0 then runs to STP with memory[18]=`0x0820` (sum 1..64).
- Single word `0x7000` with `in_last`=1: written to address 0; `done` rises; `error`=0.
- 33 words without `in_last` (`MAX_WORDS`=32):
  - 33rd word sets `error`;
  - `cpu_rst_n` stays 0; `done` stays 0.
- Macro on, bench corrupts memory[5] during `VERIFY` (write `0xFFFF`): `error`=1 in `CHECK`; core never released.
- `rst` pulsed after 10 words accepted: all outputs return to reset values within the cycle; a full reload then completes normally.
- `in_valid` held low for 5 cycles mid-stream: no memory writes, `count` unchanged; resumes correctly.
